// File: rtl/sim_run_ctrl_if.sv
// Run-controller bus: per-hart halt/exit-code inputs and run status outputs.
// master = run controller, slave = core/bench side.
interface sim_run_ctrl_if #(
  parameter int NHARTS = 4,
  parameter int CW     = 32
);
  logic [NHARTS-1:0]   halt;
  logic [8*NHARTS-1:0] halt_code;
  logic                dut_resetn;
  logic                done;
  logic                pass;
  logic                timed_out;
  logic [7:0]          exit_code;
  logic [CW-1:0]       cycles;
  logic [NHARTS-1:0]   halted_mask;

  modport master (
    input  halt, halt_code,
    output dut_resetn, done, pass, timed_out,
    output exit_code, cycles, halted_mask
  );

  modport slave (
    output halt, halt_code,
    input  dut_resetn, done, pass, timed_out,
    input  exit_code, cycles, halted_mask
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences DUT reset (HOLD), watches per-hart halts (RUN),
// freezes results (DONE). Ports: clk, resetn (sync, active-low), bus (master).
module sim_run_ctrl #(
  parameter int NHARTS       = 4,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1000,
  parameter int CW           = 32,
  parameter int HALT_MODE    = 0
) (
  input  logic          clk,
  input  logic          resetn,
  sim_run_ctrl_if.master bus
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TMO_AT    = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [HW-1:0]     hold_cnt;
  logic [7:0]        code_q [NHARTS];
  logic [NHARTS-1:0] mask_q;
  logic [NHARTS-1:0] mask_n;
  logic [NHARTS-1:0] fresh;
  logic [CW-1:0]     cyc_q;
  logic              rst_q;
  logic              done_q;
  logic              pass_q;
  logic              tmo_q;
  logic [7:0]        exit_q;

  logic [7:0] or_code;
  logic [7:0] first_code;
  logic [7:0] hit_code;
  logic       hit;
  logic       tmo;

  assign bus.dut_resetn  = rst_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timed_out   = tmo_q;
  assign bus.exit_code   = exit_q;
  assign bus.cycles      = cyc_q;
  assign bus.halted_mask = mask_q;

  always_ff @(posedge clk) begin
    if (!resetn) state <= HOLD;
    else         state <= state_n;
  end

  always_comb begin
    fresh      = bus.halt & ~mask_q;
    mask_n     = mask_q | bus.halt;
    or_code    = '0;
    first_code = '0;
    // A hart halting on this edge contributes its live code; others
    // contribute their latched first-halt code (zero if never halted).
    // Descending scan leaves the lowest halting hart in first_code.
    for (int i = NHARTS - 1; i >= 0; i--) begin
      or_code = or_code |
        (fresh[i] ? bus.halt_code[8*i +: 8] : code_q[i]);
      if (bus.halt[i]) first_code = bus.halt_code[8*i +: 8];
    end
    hit      = (HALT_MODE == 0) ? (&mask_n) : (|bus.halt);
    hit_code = (HALT_MODE == 0) ? or_code : first_code;
    tmo      = (TIMEOUT != 0) && (cyc_q == TMO_AT);
    state_n  = state;
    unique case (state)
      HOLD:    if (hold_cnt == HOLD_LAST) state_n = RUN;
      RUN:     if (hit || tmo) state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_cnt <= '0;
      rst_q    <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      tmo_q    <= 1'b0;
      exit_q   <= '0;
      cyc_q    <= '0;
      mask_q   <= '0;
      for (int i = 0; i < NHARTS; i++) code_q[i] <= '0;
    end else begin
      rst_q <= (state_n != HOLD);
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      if (state == RUN) begin
        if (~&cyc_q) cyc_q <= cyc_q + 1'b1;
        mask_q <= mask_n;
        for (int i = 0; i < NHARTS; i++)
          if (fresh[i]) code_q[i] <= bus.halt_code[8*i +: 8];
        if (hit) begin
          done_q <= 1'b1;
          exit_q <= hit_code;
          pass_q <= (hit_code == 8'h00);
        end else if (tmo) begin
          done_q <= 1'b1;
          tmo_q  <= 1'b1;
          exit_q <= 8'hFF;
          pass_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
Run controller for multi-hart barrel-core simulations. It sequences DUT reset and watches per-hart halt flags. It latches per-hart exit codes and ends the run on completion or on a cycle timeout. It sits between the bench clock/reset and the core, replacing ad-hoc halt/timeout logic in benches, and exposes done/pass/exit_code for the bench to act on.

Parameters:
NHARTS, 4, number of harts monitored (>=1)
RESET_CYCLES, 2, clk edges dut_resetn is held low after resetn goes high (>=1)
TIMEOUT, 1000, max RUN cycles before forced timeout; 0 disables timeout
CW, 32, width of cycle counter
HALT_MODE, 0, 0 = complete when all harts have halted, 1 = complete when any hart halts

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
halt  in  NHARTS  per-hart halt flag, level, sampled only in RUN
halt_code  in  8*NHARTS  per-hart exit code; hart i uses bits [8i+7:8i]; valid while halt[i]=1
dut_resetn  out  1  registered active-low reset to DUT
done  out  1  run finished, sticky
pass  out  1  valid when done=1: exit_code==0 and no timeout
timed_out  out  1  run ended by timeout, sticky
exit_code  out  8  final exit code, valid when done=1
cycles  out  CW  RUN cycle count, saturating
halted_mask  out  NHARTS  sticky per-hart halted flags

Behaviour:
- Reset (resetn=0 at posedge): state=HOLD, hold_cnt=0, dut_resetn=0, done=0, pass=0, timed_out=0, exit_code=0, cycles=0, halted_mask=0, all code latches=0.
- Reset applies from any state, mid-run included; takes effect at the next edge.
- States: HOLD -> RUN -> DONE. DONE exits only via resetn.
- HOLD:
  - hold_cnt increments each edge.
  - When hold_cnt==RESET_CYCLES-1, the next state is RUN and dut_resetn<=1 at that edge.
  - dut_resetn therefore rises on the RESET_CYCLES-th edge with resetn=1.
  - halt is ignored in HOLD.
- RUN, at every edge:
  - cycles<=cycles+1, saturating at all-ones.
  - For each i with halt[i]=1 and halted_mask[i]=0: halted_mask[i]<=1 and latch code[i]<=halt_code[i]. Codes are first-halt only; later changes are ignored.
  - hit = HALT_MODE==0 ? &(halted_mask|halt) : |halt.
  - tmo = TIMEOUT!=0 and cycles==TIMEOUT-1.
  - If hit: state<=DONE, done<=1.
    - HALT_MODE 0: exit_code<=OR over i of (code[i] or halt_code[i] where newly halting this edge).
    - HALT_MODE 1: exit_code<=halt_code of the lowest-index hart with halt=1 this edge.
    - pass<=(resulting exit_code==0).
  - Else if tmo: state<=DONE, done<=1, timed_out<=1, exit_code<=8'hFF, pass<=0.
  - Simultaneous hit and tmo: hit wins, timed_out stays 0.
- DONE:
  - All outputs frozen; dut_resetn stays 1.
  - halt, halt_code ignored; cycles stops.
- Boundaries:
  - TIMEOUT=1: timeout fires on the first RUN edge unless hit on that edge.
  - halt asserted during HOLD is not recorded.
  - Halt pulses of one cycle are captured in halted_mask.
  - HALT_MODE 0 completes on the edge where the last outstanding hart first asserts halt, even if earlier harts have deasserted.
  - cycles saturation has no effect on timeout when TIMEOUT<2^CW.
- Latency: done is asserted at the same edge that samples the completing halt (registered, visible next cycle).

Test Plan:
- Reset sequencing, RESET_CYCLES=2: release resetn -> dut_resetn=0 after edge 1, =1 after edge 2; halt=4'hF held during HOLD -> halted_mask=0, done=0.
- HALT_MODE 0, all codes 0: harts 0..3 halt at RUN cycles 5,9,9,20 (hart0 pulses 1 cycle) -> done at cycles=20, pass=1, exit_code=0, halted_mask=4'hF.
- HALT_MODE 0, codes: hart1 code 8'h02 at first halt, then changes to 8'h07; hart3 code 8'h10 -> exit_code=8'h12, pass=0.
- HALT_MODE 1: harts 2 and 1 halt on the same edge with codes 8'h05/8'h03 -> exit_code=8'h03, done=1, pass=0.
- Timeout, TIMEOUT=50, no halts -> done=1, timed_out=1, exit_code=8'hFF, cycles=50.
- Timeout tie: last hart halts on RUN cycle 50 -> timed_out=0, pass per codes.
- Mid-run reset: resetn=0 at RUN cycle 30 -> all outputs at reset values next edge; the HOLD sequence repeats on release.
